// File: rtl/pifo_dequeue_ctrl.sv
// ---------------------------------------------------------------------------
// pifo_dequeue_ctrl
//
// Pulls buffer addresses off the head of a PIFO calendar and hands them to
// the packet-buffer reader through a small output FIFO with an AXI-Stream
// style handshake.
//
// A three-state FSM (DISABLED / RUN / DRAIN) decides whether popping is
// allowed. Popping happens only in RUN, while enabled and not paused, when
// the calendar head is valid and the FIFO has room. Words already in the
// FIFO keep flowing out in every state, so a disable or pause stops new pops
// but never strands queued addresses.
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   s_head_addr     buffer address of the calendar head element
//   s_head_valid    calendar head holds a valid entry
//   m_pop_en        pop request to the calendar (one pop per asserted cycle)
//   in_pause        hold popping (CPU-write path)
//   in_enable       dequeue enable
//   m_axis_tdata    oldest queued buffer address
//   m_axis_tvalid   m_axis_tdata is valid (FIFO not empty)
//   m_axis_tready   consumer accepts the current word
//   out_drained     FSM is DISABLED and the FIFO is empty
//   out_fifo_level  current FIFO occupancy, 0..OUT_FIFO_DEPTH
//   stat_pop_count  saturating count of pops since reset or clear
//   stat_clear      clear stat_pop_count (wins over a same-cycle pop)
// ---------------------------------------------------------------------------
module pifo_dequeue_ctrl #(
  parameter int BUFFER_ADDR_WIDTH  = 12,
  parameter int OUT_FIFO_DEPTH     = 4,
  parameter int OUT_FIFO_PTR_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BUFFER_ADDR_WIDTH-1:0]  s_head_addr,
  input  logic                          s_head_valid,
  output logic                          m_pop_en,
  input  logic                          in_pause,
  input  logic                          in_enable,
  output logic [BUFFER_ADDR_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          out_drained,
  output logic [OUT_FIFO_PTR_WIDTH:0]   out_fifo_level,
  output logic [31:0]                   stat_pop_count,
  input  logic                          stat_clear
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [OUT_FIFO_PTR_WIDTH:0] FIFO_FULL_COUNT =
    (OUT_FIFO_PTR_WIDTH+1)'(OUT_FIFO_DEPTH);

  state_t state_reg;
  state_t state_next;

  logic [OUT_FIFO_PTR_WIDTH-1:0] wr_ptr_reg;
  logic [OUT_FIFO_PTR_WIDTH-1:0] rd_ptr_reg;
  logic [OUT_FIFO_PTR_WIDTH:0]   count_reg;
  logic [OUT_FIFO_PTR_WIDTH:0]   count_next;

  // Small register-file FIFO: the oldest word must be visible on the same
  // cycle it becomes valid, so the read side is an asynchronous mux rather
  // than a registered RAM read.
  logic [BUFFER_ADDR_WIDTH-1:0]  fifo_mem_reg [OUT_FIFO_DEPTH];
  logic [OUT_FIFO_DEPTH-1:0]     entry_we;

  logic [31:0] stat_pop_count_reg;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_wr;
  logic fifo_rd;
  logic tvalid_int;

  // -------------------------------------------------------------------------
  // Status and handshake
  // -------------------------------------------------------------------------
  assign fifo_full  = (count_reg == FIFO_FULL_COUNT);
  assign fifo_empty = (count_reg == '0);

  // Gating with rst keeps outputs at their reset values during the reset
  // cycle itself, so nothing is handed out while entries are being thrown
  // away.
  assign tvalid_int = !fifo_empty && !rst;
  assign fifo_rd    = tvalid_int && m_axis_tready;

  // Full blocks popping on the registered count even if a handshake frees
  // a slot this cycle; this keeps s_head_valid -> m_pop_en free of any path
  // through m_axis_tready.
  assign m_pop_en = !rst && (state_reg == RUN) && in_enable && !in_pause &&
                    s_head_valid && !fifo_full;
  assign fifo_wr  = m_pop_en;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DISABLED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      DISABLED: begin
        if (in_enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!in_enable) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (in_enable) begin
          state_next = RUN;
        end else if (fifo_empty && !fifo_wr) begin
          state_next = DISABLED;
        end
      end
      default: state_next = DISABLED;
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO storage: one write-enable per entry decoded from the write pointer
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < OUT_FIFO_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = fifo_wr &&
                            (wr_ptr_reg == OUT_FIFO_PTR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
      if (entry_we[i]) begin
        fifo_mem_reg[i] <= s_head_addr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy. Depth is a power of two, so the pointers
  // wrap naturally at their width.
  // -------------------------------------------------------------------------
  always_comb begin
    count_next = count_reg;
    unique case ({fifo_wr, fifo_rd})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_rd) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Pop statistics: saturating, clear has priority over a same-cycle pop
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_pop_count_reg <= '0;
    end else if (m_pop_en && (stat_pop_count_reg != 32'hFFFF_FFFF)) begin
      stat_pop_count_reg <= stat_pop_count_reg + 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign m_axis_tvalid  = tvalid_int;
  assign m_axis_tdata   = fifo_mem_reg[rd_ptr_reg];
  assign out_fifo_level = rst ? '0 : count_reg;
  assign out_drained    = rst || ((state_reg == DISABLED) && fifo_empty);
  assign stat_pop_count = stat_pop_count_reg;

endmodule

// File: tb/tb_pifo_dequeue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pifo_dequeue_ctrl
//
// Directed test of pifo_dequeue_ctrl. The stimulus side models the calendar
// head (a run of consecutive addresses that advances on each pop) and pushes
// the addresses it expects to see into a scoreboard queue; a separate
// monitor compares every output handshake against the queue front.
// Inputs change on the falling edge; the monitor samples 2 ns later.
// ---------------------------------------------------------------------------
module tb_pifo_dequeue_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_head_addr;
  logic          s_head_valid;
  logic          m_pop_en;
  logic          in_pause;
  logic          in_enable;
  logic [AW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          out_drained;
  logic [2:0]    out_fifo_level;
  logic [31:0]   stat_pop_count;
  logic          stat_clear;

  always #5 clk = ~clk;

  pifo_dequeue_ctrl #(
    .BUFFER_ADDR_WIDTH (AW),
    .OUT_FIFO_DEPTH    (4),
    .OUT_FIFO_PTR_WIDTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_head_addr   (s_head_addr),
    .s_head_valid  (s_head_valid),
    .m_pop_en      (m_pop_en),
    .in_pause      (in_pause),
    .in_enable     (in_enable),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .out_drained   (out_drained),
    .out_fifo_level(out_fifo_level),
    .stat_pop_count(stat_pop_count),
    .stat_clear    (stat_clear)
  );

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [AW-1:0] exp_q[$];
  int            hs_count = 0;

  // Calendar model state
  int            pops_seen = 0;
  int            head_left = 0;
  logic [AW-1:0] next_addr = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: present the calendar head, note whether a pop is requested
  // for the coming rising edge, advance the head if so. Called at a falling
  // edge, returns at the next falling edge.
  task automatic cycle();
    s_head_addr  = next_addr;
    s_head_valid = (head_left > 0);
    #1;
    if (m_pop_en) begin
      pops_seen++;
      next_addr = next_addr + 1'b1;
      head_left--;
    end
    @(negedge clk);
  endtask

  task automatic push_range(input logic [AW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(first + AW'(i));
    end
  endtask

  task automatic wait_empty(input string name, input int bound);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_fifo_level != 0) && c < bound) begin
      cycle();
      c++;
    end
    check({name, "_drain_in_time"}, 32'(c < bound), 32'd1);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic [AW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_word: got 0x%03h, expected no word", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] handshake tdata=0x%03h expected=0x%03h", m_axis_tdata, e);
          check("tdata", 32'(m_axis_tdata), 32'(e));
        end
      end
    end
  end

  initial begin : stimulus
    int base;
    int hs_base;
    int first_c;
    int last_c;
    int p;
    int c;

    rst           = 1'b1;
    s_head_addr   = '0;
    s_head_valid  = 1'b0;
    in_pause      = 1'b0;
    in_enable     = 1'b0;
    m_axis_tready = 1'b0;
    stat_clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_tvalid",  32'(m_axis_tvalid),  32'd0);
    check("rst_level",   32'(out_fifo_level), 32'd0);
    check("rst_pop_en",  32'(m_pop_en),       32'd0);
    check("rst_drained", 32'(out_drained),    32'd1);
    check("rst_stat",    stat_pop_count,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- basic dequeue -------------------------------------------------
    base = pops_seen;
    in_enable = 1'b1;
    m_axis_tready = 1'b1;
    head_left = 3;
    next_addr = 12'h010;
    push_range(12'h010, 3);
    first_c = -1;
    last_c = -1;
    for (int i = 0; i < 8; i++) begin
      p = pops_seen;
      cycle();
      if (pops_seen != p) begin
        if (first_c < 0) begin
          first_c = i;
          check("basic_tvalid_latency", 32'(m_axis_tvalid), 32'd1);
          check("basic_first_tdata", 32'(m_axis_tdata), 32'h010);
        end
        last_c = i;
      end
    end
    check("basic_pops", 32'(pops_seen - base), 32'd3);
    check("basic_back_to_back", 32'(last_c - first_c), 32'd2);
    wait_empty("basic", 10);
    check("basic_stat", stat_pop_count, 32'd3);

    // ---- backpressure ----------------------------------------------------
    base = pops_seen;
    hs_base = hs_count;
    m_axis_tready = 1'b0;
    head_left = 10;
    next_addr = 12'h100;
    push_range(12'h100, 10);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (m_axis_tvalid) begin
        check("bp_tdata_hold", 32'(m_axis_tdata), 32'h100);
      end
    end
    #1;
    check("bp_pops_when_full", 32'(pops_seen - base), 32'd4);
    check("bp_pop_en_full", 32'(m_pop_en), 32'd0);
    check("bp_level_full", 32'(out_fifo_level), 32'd4);
    m_axis_tready = 1'b1;
    c = 0;
    while ((pops_seen - base < 10) && c < 40) begin
      cycle();
      c++;
    end
    wait_empty("bp", 10);
    check("bp_pops_total", 32'(pops_seen - base), 32'd10);
    check("bp_handshakes", 32'(hs_count - hs_base), 32'd10);
    check("bp_stat", stat_pop_count, 32'd13);

    // ---- pause -----------------------------------------------------------
    base = pops_seen;
    m_axis_tready = 1'b0;
    head_left = 2;
    next_addr = 12'h200;
    push_range(12'h200, 2);
    for (int i = 0; i < 4; i++) cycle();
    check("pause_level_before", 32'(out_fifo_level), 32'd2);
    in_pause = 1'b1;
    head_left = 5;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("pause_no_pops", 32'(pops_seen - base), 32'd2);
    check("pause_level_after", 32'(out_fifo_level), 32'd0);
    check("pause_delivered", 32'(exp_q.size()), 32'd0);
    in_pause = 1'b0;
    head_left = 0;

    // ---- drain -----------------------------------------------------------
    base = pops_seen;
    hs_base = hs_count;
    m_axis_tready = 1'b0;
    head_left = 3;
    next_addr = 12'h300;
    push_range(12'h300, 3);
    for (int i = 0; i < 5; i++) cycle();
    check("drain_level_before", 32'(out_fifo_level), 32'd3);
    check("drain_not_drained", 32'(out_drained), 32'd0);
    in_enable = 1'b0;
    head_left = 5;
    m_axis_tready = 1'b1;
    c = 0;
    while (!out_drained && c < 12) begin
      cycle();
      c++;
    end
    check("drain_drained", 32'(out_drained), 32'd1);
    check("drain_no_more_pops", 32'(pops_seen - base), 32'd3);
    check("drain_handshakes", 32'(hs_count - hs_base), 32'd3);
    check("drain_level_after", 32'(out_fifo_level), 32'd0);
    head_left = 0;

    // ---- counter saturation and clear ------------------------------------
    force dut.stat_pop_count_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stat_pop_count_reg;
    check("cnt_preload", stat_pop_count, 32'hFFFF_FFFE);
    base = pops_seen;
    in_enable = 1'b1;
    m_axis_tready = 1'b1;
    head_left = 3;
    next_addr = 12'h400;
    push_range(12'h400, 3);
    c = 0;
    while ((pops_seen - base < 3) && c < 10) begin
      cycle();
      c++;
    end
    check("cnt_pops", 32'(pops_seen - base), 32'd3);
    check("cnt_saturated", stat_pop_count, 32'hFFFF_FFFF);
    base = pops_seen;
    head_left = 1;
    next_addr = 12'h500;
    push_range(12'h500, 1);
    stat_clear = 1'b1;
    cycle();
    stat_clear = 1'b0;
    check("clr_pop_happened", 32'(pops_seen - base), 32'd1);
    check("clr_count_zero", stat_pop_count, 32'd0);
    head_left = 1;
    next_addr = 12'h501;
    push_range(12'h501, 1);
    cycle();
    check("clr_count_resume", stat_pop_count, 32'd1);
    wait_empty("cnt", 10);

    // ---- reset mid-operation ---------------------------------------------
    base = pops_seen;
    m_axis_tready = 1'b0;
    head_left = 3;
    next_addr = 12'h600;
    c = 0;
    while ((pops_seen - base < 3) && c < 8) begin
      cycle();
      c++;
    end
    check("rstmid_level_before", 32'(out_fifo_level), 32'd3);
    base = pops_seen;
    hs_base = hs_count;
    rst = 1'b1;
    m_axis_tready = 1'b1;
    head_left = 5;
    cycle();
    rst = 1'b0;
    #1;
    check("rstmid_no_pop", 32'(pops_seen - base), 32'd0);
    check("rstmid_no_hs", 32'(hs_count - hs_base), 32'd0);
    check("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rstmid_level", 32'(out_fifo_level), 32'd0);
    check("rstmid_pop_en", 32'(m_pop_en), 32'd0);
    check("rstmid_drained", 32'(out_drained), 32'd1);
    check("rstmid_stat", stat_pop_count, 32'd0);

    in_enable = 1'b0;
    head_left = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a wait above goes wrong.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
